// File: rtl/instruction_fetch_unit.sv
// Multi-cycle instruction fetch front end: owns the PC, fetches over a req/ready
// handshake, holds the instruction until retired and stops on ECALL halt or misaligned PC.
module instruction_fetch_unit #(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0]   NOP_INST = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            pc_update,
   input  logic [XLEN-1:0] pc_next,
   input  logic            halt,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [6:0]      part_of_inst,
   output logic [XLEN-1:0] pc,
   output logic            halted,
   output logic            fault,
   output logic [31:0]     fetch_count
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t state;

   // Gating with reset drops the request the instant reset asserts mid-handshake
   assign imem_req     = (state == FETCH) && reset;
   assign imem_addr    = pc;
   assign part_of_inst = inst[6:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         inst        <= NOP_INST;
         inst_valid  <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  inst        <= imem_rdata;
                  inst_valid  <= 1'b1;
                  fetch_count <= fetch_count + 32'd1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (pc_update) begin
                  inst_valid <= 1'b0;
                  inst       <= NOP_INST;
                  // Halt wins over misalignment; on either stop pc keeps the retiring PC
                  if (halt) begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end else if (pc_next[1:0] != 2'b00) begin
                     halted <= 1'b1;
                     fault  <= 1'b1;
                     state  <= HALT;
                  end else begin
                     pc    <= pc_next;
                     state <= FETCH;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with hand-computed expectations.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        pc_update;
   logic [31:0] pc_next;
   logic        halt;
   logic        inst_valid;
   logic [31:0] inst;
   logic [6:0]  part_of_inst;
   logic [31:0] pc;
   logic        halted;
   logic        fault;
   logic [31:0] fetch_count;

   int total;
   int bad;

   localparam logic [31:0] NOP = 32'h0000_0013;

   instruction_fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .pc_update    (pc_update),
      .pc_next      (pc_next),
      .halt         (halt),
      .inst_valid   (inst_valid),
      .inst         (inst),
      .part_of_inst (part_of_inst),
      .pc           (pc),
      .halted       (halted),
      .fault        (fault),
      .fetch_count  (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ready, input logic [31:0] rdata,
                                input logic upd, input logic hlt, input logic [31:0] nxt);
      imem_ready = ready;
      imem_rdata = rdata;
      pc_update  = upd;
      halt       = hlt;
      pc_next    = nxt;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);

      // Reset values
      checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
      checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("rst_inst", inst, NOP);
      checkOutput("rst_part", {25'b0, part_of_inst}, 32'h13);
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_halted", {31'b0, halted}, 32'd0);
      checkOutput("rst_fault", {31'b0, fault}, 32'd0);
      checkOutput("rst_count", fetch_count, 32'd0);

      // Zero-wait fetch at address 0
      applyStimulus(1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      #1;
      checkOutput("zw_req", {31'b0, imem_req}, 32'd1);
      checkOutput("zw_addr", imem_addr, 32'h0);
      @(negedge clk);
      checkOutput("zw_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("zw_inst", inst, 32'h0000_0033);
      checkOutput("zw_part", {25'b0, part_of_inst}, 32'h33);
      checkOutput("zw_count", fetch_count, 32'd1);
      checkOutput("zw_req_off", {31'b0, imem_req}, 32'd0);

      // HOLD for 5 cycles with ready still toggling; nothing may move
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i[0], 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput("hold_inst", inst, 32'h0000_0033);
         checkOutput("hold_req", {31'b0, imem_req}, 32'd0);
         checkOutput("hold_count", fetch_count, 32'd1);
      end

      // Retire to pc 0x8
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h8);
      @(negedge clk);
      checkOutput("upd_pc", pc, 32'h8);
      checkOutput("upd_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("upd_inst", inst, NOP);
      checkOutput("upd_req", {31'b0, imem_req}, 32'd1);
      checkOutput("upd_addr", imem_addr, 32'h8);

      applyStimulus(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("f8_inst", inst, 32'h0050_0093);
      checkOutput("f8_part", {25'b0, part_of_inst}, 32'h13);
      checkOutput("f8_count", fetch_count, 32'd2);

      // Fetch at 0x10 with 3 wait cycles
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10);
      @(negedge clk);
      checkOutput("w_req0", {31'b0, imem_req}, 32'd1);
      checkOutput("w_addr0", imem_addr, 32'h10);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput("w_req", {31'b0, imem_req}, 32'd1);
         checkOutput("w_addr", imem_addr, 32'h10);
         checkOutput("w_valid", {31'b0, inst_valid}, 32'd0);
         checkOutput("w_inst", inst, NOP);
         checkOutput("w_count", fetch_count, 32'd2);
      end
      applyStimulus(1'b1, 32'h0000_0073, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("w_inst_cap", inst, 32'h0000_0073);
      checkOutput("w_count_cap", fetch_count, 32'd3);
      checkOutput("w_valid_cap", {31'b0, inst_valid}, 32'd1);

      // ECALL halt
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h14);
      @(negedge clk);
      checkOutput("ec_halted", {31'b0, halted}, 32'd1);
      checkOutput("ec_fault", {31'b0, fault}, 32'd0);
      checkOutput("ec_pc", pc, 32'h10);
      checkOutput("ec_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("ec_inst", inst, NOP);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i[0], 32'h0000_0033, 1'b1, 1'b0, 32'h4);
         @(negedge clk);
         checkOutput("ht_req", {31'b0, imem_req}, 32'd0);
         checkOutput("ht_count", fetch_count, 32'd3);
         checkOutput("ht_pc", pc, 32'h10);
         checkOutput("ht_halted", {31'b0, halted}, 32'd1);
      end

      // Asynchronous reset from HALT, then restart at RESET_PC
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #2 reset = 1'b0;
      #1;
      checkOutput("ar_pc", pc, 32'h0);
      checkOutput("ar_halted", {31'b0, halted}, 32'd0);
      checkOutput("ar_count", fetch_count, 32'd0);
      @(negedge clk);
      applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      #1;
      checkOutput("rs_req", {31'b0, imem_req}, 32'd1);
      checkOutput("rs_addr", imem_addr, 32'h0);
      @(negedge clk);
      checkOutput("rs_count", fetch_count, 32'd1);
      checkOutput("rs_valid", {31'b0, inst_valid}, 32'd1);

      // Misaligned pc_next
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h6);
      @(negedge clk);
      checkOutput("mis_halted", {31'b0, halted}, 32'd1);
      checkOutput("mis_fault", {31'b0, fault}, 32'd1);
      checkOutput("mis_pc", pc, 32'h0);
      checkOutput("mis_valid", {31'b0, inst_valid}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput("mis_req", {31'b0, imem_req}, 32'd0);
         checkOutput("mis_count", fetch_count, 32'd1);
      end

      // Halt has priority over a misaligned pc_next
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(1'b1, 32'h0000_0073, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h6);
      @(negedge clk);
      checkOutput("pri_halted", {31'b0, halted}, 32'd1);
      checkOutput("pri_fault", {31'b0, fault}, 32'd0);

      // Self-loop refetch, then reset mid-handshake
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("sl_pc", pc, 32'h0);
      checkOutput("sl_req", {31'b0, imem_req}, 32'd1);
      applyStimulus(1'b1, 32'h0000_0037, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("sl_count", fetch_count, 32'd2);
      checkOutput("sl_inst", inst, 32'h0000_0037);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20);
      @(negedge clk);
      checkOutput("mh_addr", imem_addr, 32'h20);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("mh_req", {31'b0, imem_req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("mh_req_drop", {31'b0, imem_req}, 32'd0);
      checkOutput("mh_pc", pc, 32'h0);
      checkOutput("mh_count", fetch_count, 32'd0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput("late_valid", {31'b0, inst_valid}, 32'd0);
         checkOutput("late_count", fetch_count, 32'd0);
         checkOutput("late_inst", inst, NOP);
         checkOutput("late_req", {31'b0, imem_req}, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Multi-cycle instruction fetch front end. It produces the instruction word whose opcode field drives the control decoder's `part_of_inst` input.
- Owns the PC and issues instruction-memory reads over a req/ready handshake.
- Holds the fetched instruction stable until the datapath retires it, then loads the next PC.
- Stops fetching on an ECALL-driven halt or on a misaligned next PC.

Parameters:
XLEN, 32, width of PC and instruction word
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INST, 32'h0000_0013, instruction register value while no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  instruction read request
imem_addr  out  XLEN  read address (equals pc)
imem_ready  in  1  memory has valid data on imem_rdata this cycle
imem_rdata  in  XLEN  instruction read data
pc_update  in  1  datapath retires the held instruction this cycle
pc_next  in  XLEN  next PC from datapath; sampled when pc_update=1
halt  in  1  retiring instruction is ECALL-halt (is_ecall && x17==10); qualified by pc_update
inst_valid  out  1  inst holds a fetched, unretired instruction
inst  out  XLEN  instruction register
part_of_inst  out  7  inst[6:0], to control decoder
pc  out  XLEN  PC of the held or in-flight instruction
halted  out  1  fetch stopped (sticky until reset)
fault  out  1  stop was caused by a misaligned pc_next (sticky)
fetch_count  out  32  number of completed fetches, wraps at 2^32

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, pc=RESET_PC, inst=NOP_INST.
  - inst_valid=0, halted=0, fault=0, fetch_count=0, imem_req=0.
  - Reset asserted mid-handshake aborts the fetch immediately; the pending read is discarded.
- States are FETCH, HOLD and HALT. All outputs are registered except imem_req, imem_addr and part_of_inst.
  - imem_req = (state==FETCH) && reset.
  - imem_addr = pc.
  - part_of_inst = inst[6:0].
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until accepted.
  - On a rising edge with imem_ready=1: inst<=imem_rdata, inst_valid<=1, fetch_count<=fetch_count+1, state<=HOLD.
  - A combinational same-cycle ready is legal, so a zero-wait memory yields inst_valid one cycle after req rises.
  - pc_update and halt are ignored in FETCH.
- HOLD:
  - imem_req=0; inst and pc are stable; imem_ready is ignored.
  - pc_update=0: stay in HOLD.
  - pc_update=1 and halt=1: state<=HALT, halted<=1, inst_valid<=0, inst<=NOP_INST. pc is unchanged and keeps the ECALL's PC.
  - pc_update=1, halt=0, pc_next[1:0]!=0: state<=HALT, halted<=1, fault<=1, inst_valid<=0, inst<=NOP_INST. pc is unchanged.
  - pc_update=1, halt=0, aligned pc_next: pc<=pc_next, inst_valid<=0, inst<=NOP_INST, state<=FETCH. New req is asserted the following cycle.
  - halt takes priority over the misalignment check.
- HALT: terminal state; no requests issued; all inputs ignored; exit only via reset.
- pc_next==pc (self-loop) is legal and refetches the same address.
- fetch_count wraps from 32'hFFFF_FFFF to 0 with no flag.
- Zero-wait steady-state throughput: one instruction per 2 cycles (FETCH, HOLD with pc_update=1).

Test Plan:
- Reset then zero-wait memory (ready=1) returning 32'h0000_0033 at addr 0 -> req=1, addr=0 in cycle 1; cycle 2 inst_valid=1, inst=32'h33, part_of_inst=7'h33, fetch_count=1.
- Memory with 3 wait cycles at addr 0x10 -> req and addr=0x10 held stable for 4 cycles; inst captured only on the ready edge; fetch_count increments once.
- HOLD with pc_update=0 for 5 cycles, then pc_update=1 with pc_next=0x8 -> inst stable throughout; next cycle pc=0x8, inst_valid=0, inst=NOP_INST, req=1.
- ECALL 32'h0000_0073 held, pc_update=1 with halt=1 -> halted=1, fault=0, pc unchanged, req stays 0 even with ready toggling; reset release restarts at RESET_PC.
- pc_update=1, halt=0, pc_next=0x6 -> halted=1, fault=1, pc unchanged, no further requests.
- Reset asserted while req=1 and ready=0 -> outputs return to reset values asynchronously; a late ready during reset is ignored; fetch_count=0.
